// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_encoder_pkg
// Summary : RV32I format codes, opcodes and field packing shared with decode
// Rev     : 1.0
// ============================================================================
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_req_t;

    // Fields a format does not carry are left zero; fit must be checked separately.
    function automatic logic [31:0] pack_fields(enc_req_t r);
        logic [31:0] w_word;
        w_word = c_NOP_INSTR;
        case (r.fmt)
            FMT_R: w_word = {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, r.opcode};
            FMT_I: w_word = {r.imm[11:0], r.rs1, r.funct3, r.rd, r.opcode};
            FMT_S: w_word = {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], r.opcode};
            FMT_B: w_word = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.funct3,
                             r.imm[4:1], r.imm[11], r.opcode};
            FMT_U: w_word = {r.imm[31:12], r.rd, r.opcode};
            FMT_J: w_word = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12],
                             r.rd, r.opcode};
            default: w_word = c_NOP_INSTR;
        endcase
        return w_word;
    endfunction

endpackage : instr_encoder_pkg
`default_nettype wire

// File: rtl/instr_encoder_imm_fit_check.sv
`default_nettype none
// ============================================================================
// Module  : imm_fit_check
// Summary : combinational test that an immediate is representable in a format
// Rev     : 1.0
// ============================================================================
module imm_fit_check
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [31:0] i_imm,
    output logic        o_fits
);

    // Range checks are sign-extension checks on the top bits of the immediate.
    always_comb begin
        o_fits = 1'b0;
        case (i_fmt)
            FMT_R:        o_fits = 1'b1;
            FMT_I, FMT_S: o_fits = (i_imm[31:11] == {21{i_imm[11]}});
            FMT_B:        o_fits = (i_imm[31:12] == {20{i_imm[12]}}) && !i_imm[0];
            FMT_J:        o_fits = (i_imm[31:20] == {12{i_imm[20]}}) && !i_imm[0];
            FMT_U:        o_fits = (i_imm[11:0] == 12'd0);
            default:      o_fits = 1'b0;
        endcase
    end

endmodule : imm_fit_check
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module  : instr_encoder
// Summary : two-stage RV32I instruction encoder (check, then pack) with handshake
// Rev     : 1.0
// ============================================================================
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err
);

    enc_req_t    w_req;
    logic        w_fits;
    logic        w_s2_ready;
    logic        w_s1_advance;
    logic        w_accept;
    logic        w_s1_err;
    logic [31:0] w_packed;

    enc_req_t    r_s1_req;
    logic        r_s1_fits;
    logic        r_s1_valid;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic        r_out_err;

    assign w_req = '{fmt:    in_fmt,
                     opcode: in_opcode,
                     rd:     in_rd,
                     rs1:    in_rs1,
                     rs2:    in_rs2,
                     funct3: in_funct3,
                     funct7: in_funct7,
                     imm:    in_imm};

    imm_fit_check u_fit (
        .i_fmt  (in_fmt),
        .i_imm  (in_imm),
        .o_fits (w_fits)
    );

    // Each stage may load when it is empty or emptying this cycle.
    assign w_s2_ready   = !r_out_valid || out_ready;
    assign w_s1_advance = r_s1_valid && w_s2_ready;
    assign in_ready     = !r_s1_valid || w_s2_ready;
    assign w_accept     = in_valid && in_ready;

    // Illegal formats report not-fitting, so they collapse into the error path.
    assign w_s1_err = !r_s1_fits;
    assign w_packed = w_s1_err ? c_NOP_INSTR : pack_fields(r_s1_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_req    <= '0;
            r_s1_fits   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_instr <= 32'd0;
            r_out_err   <= 1'b0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_accept) begin
                r_s1_req  <= w_req;
                r_s1_fits <= w_fits;
            end
            if (w_s2_ready) begin
                r_out_valid <= r_s1_valid;
            end
            if (w_s1_advance) begin
                r_out_instr <= w_packed;
                r_out_err   <= w_s1_err;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_err   = r_out_err;

endmodule : instr_encoder
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_encoder
// Summary : self-checking bench for instr_encoder (vector table + random model)
// Rev     : 1.0
// ============================================================================
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err)
    );

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [2:0]  fmt;
        logic [31:0] imm;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm,
                                input logic [31:0] ei, input logic ee);
        vec_t v;
        v = '{fmt: fmt, op: op, rd: rd, rs1: rs1, rs2: rs2, f3: f3, f7: f7,
              imm: imm, exp_instr: ei, exp_err: ee};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_fmt    = v.fmt;
        in_opcode = v.op;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_imm    = v.imm;
    endtask

    // Reference encoder: representability from signed ranges, fields placed by shifts.
    function automatic void model(input logic [2:0] fmt, input logic [6:0] op,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [31:0] imm,
                                  output logic [31:0] instr, output logic err);
        longint      s;
        logic        fits;
        logic [31:0] base;
        s = longint'($signed(imm));
        case (fmt)
            3'd0:       fits = 1'b1;
            3'd1, 3'd2: fits = (s >= -2048) && (s <= 2047);
            3'd3:       fits = (s >= -4096) && (s <= 4094) && ((imm & 32'd1) == 0);
            3'd4:       fits = ((imm & 32'hFFF) == 0);
            3'd5:       fits = (s >= -1048576) && (s <= 1048574) && ((imm & 32'd1) == 0);
            default:    fits = 1'b0;
        endcase
        base = 32'(op);
        case (fmt)
            3'd0: instr = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                        | (32'(f3) << 12) | (32'(rd) << 7) | base;
            3'd1: instr = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                        | (32'(rd) << 7) | base;
            3'd2: instr = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20)
                        | (32'(rs1) << 15) | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | base;
            3'd3: instr = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                        | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                        | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | base;
            3'd4: instr = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | base;
            3'd5: instr = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                        | (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000F_F000)
                        | (32'(rd) << 7) | base;
            default: instr = 32'h13;
        endcase
        if (!fits) instr = 32'h0000_0013;
        err = !fits;
    endfunction

    // Decode-side immediate generator, used for the round-trip property.
    function automatic logic [31:0] imm_gen(input logic [2:0] fmt, input logic [31:0] w);
        logic [31:0] r;
        case (fmt)
            3'd1:    r = {{20{w[31]}}, w[31:20]};
            3'd2:    r = {{20{w[31]}}, w[31:25], w[11:7]};
            3'd3:    r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd4:    r = {w[31:12], 12'd0};
            3'd5:    r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic gen_random();
        int kind;
        in_fmt    = 3'($urandom_range(0, 5));
        in_opcode = 7'($urandom);
        in_rd     = 5'($urandom);
        in_rs1    = 5'($urandom);
        in_rs2    = 5'($urandom);
        in_funct3 = 3'($urandom);
        in_funct7 = 7'($urandom);
        kind      = $urandom_range(0, 9);
        if (kind == 0) begin
            in_fmt = 3'($urandom_range(0, 7));
            in_imm = $urandom;
        end else begin
            case (in_fmt)
                3'd1, 3'd2: in_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                3'd3:       in_imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
                3'd4:       in_imm = $urandom & 32'hFFFF_F000;
                3'd5:       in_imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
                default:    in_imm = $urandom;
            endcase
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        drive(mk(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b0));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got[$];
        logic [31:0] m_instr;
        logic        m_err;
        logic        took;
        int          n_acc;
        int          n_out;
        int          w;

        //        fmt   op        rd     rs1    rs2    f3    f7      imm            instr         err
        vecs.push_back(mk(3'd1, 7'h13, 5'd1,  5'd0, 5'd5, 3'd0, 7'h7F, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0));
        vecs.push_back(mk(3'd2, 7'h23, 5'd31, 5'd3, 5'd2, 3'd2, 7'h7F, 32'hFFFF_FFFC, 32'hFE21_AE23, 1'b0));
        vecs.push_back(mk(3'd5, 7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0));
        vecs.push_back(mk(3'd3, 7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'd5,         32'h0000_0013, 1'b1));
        vecs.push_back(mk(3'd1, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,      32'h0000_0013, 1'b1));
        vecs.push_back(mk(3'd7, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd0,         32'h0000_0013, 1'b1));
        vecs.push_back(mk(3'd6, 7'h33, 5'd1,  5'd2, 5'd3, 3'd0, 7'h00, 32'd0,         32'h0000_0013, 1'b1));
        vecs.push_back(mk(3'd1, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd2047,      32'h7FF0_0093, 1'b0));
        vecs.push_back(mk(3'd1, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 1'b0));
        vecs.push_back(mk(3'd1, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F7FF, 32'h0000_0013, 1'b1));
        vecs.push_back(mk(3'd3, 7'h63, 5'd9,  5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,      32'h7E00_0FE3, 1'b0));
        vecs.push_back(mk(3'd3, 7'h63, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F000, 32'h8000_0063, 1'b0));
        vecs.push_back(mk(3'd3, 7'h63, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,      32'h0000_0013, 1'b1));
        vecs.push_back(mk(3'd5, 7'h6F, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h000F_FFFE, 32'h7FFF_F06F, 1'b0));
        vecs.push_back(mk(3'd5, 7'h6F, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, 32'h0000_0013, 1'b1));
        vecs.push_back(mk(3'd5, 7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd3,         32'h0000_0013, 1'b1));
        vecs.push_back(mk(3'd4, 7'h37, 5'd1,  5'd4, 5'd5, 3'd7, 7'h00, 32'h1234_5000, 32'h1234_50B7, 1'b0));
        vecs.push_back(mk(3'd4, 7'h37, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 32'h0000_0013, 1'b1));
        vecs.push_back(mk(3'd0, 7'h33, 5'd3,  5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0));
        vecs.push_back(mk(3'd2, 7'h23, 5'd0,  5'd3, 5'd2, 3'd2, 7'h00, 32'd2048,      32'h0000_0013, 1'b1));

        rst       = 1'b1;
        out_ready = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd1 - 32'd1);
        check("reset_out_instr", out_instr, 32'd0);
        check("reset_out_err",   32'(out_err), 32'd0);
        check("reset_in_ready",  32'(in_ready), 32'd1);

        // Table vectors, one at a time, also confirming the two-cycle latency.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            w = 0;
            #1;
            while (!in_ready && w < 10) begin
                @(negedge clk);
                w++;
            end
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("vec%0d_lat1_valid", i), 32'(out_valid), 32'd0);
            @(negedge clk);
            check($sformatf("vec%0d_lat2_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp_instr);
            check($sformatf("vec%0d_err", i), 32'(out_err), 32'(vecs[i].exp_err));
        end

        // Backpressure: two requests fill the pipe, the third waits.
        @(negedge clk);
        out_ready = 1'b0;
        drive(vecs[0]);
        in_valid = 1'b1;
        #1;
        check("bp_ready_a", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(vecs[1]);
        #1;
        check("bp_ready_b", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(vecs[2]);
        repeat (3) begin
            #1;
            check("bp_full_ready", 32'(in_ready), 32'd0);
            check("bp_hold_instr", out_instr, vecs[0].exp_instr);
            @(negedge clk);
        end
        out_ready = 1'b1;
        took = 1'b0;
        for (int c = 0; c < 20 && got.size() < 3; c++) begin
            #1;
            if (out_valid) got.push_back(out_instr);
            if (in_valid && in_ready) took = 1'b1;
            @(negedge clk);
            if (took) in_valid = 1'b0;
        end
        check("bp_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_order%0d", i), (got.size() > i) ? got[i] : 32'hxxxx_xxxx,
                  vecs[i].exp_instr);
        end
        repeat (3) begin
            @(negedge clk);
            check("bp_no_dup", 32'(out_valid), 32'd0);
        end

        // Reset with both stages full and a request pending.
        idle();
        out_ready = 1'b0;
        @(negedge clk);
        drive(vecs[7]);
        in_valid = 1'b1;
        @(negedge clk);
        drive(vecs[8]);
        @(negedge clk);
        drive(vecs[10]);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_out_err",   32'(out_err), 32'd0);
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rst_flush", 32'(out_valid), 32'd0);
        end

        // Reset wins over a request presented on the same edge.
        drive(vecs[7]);
        in_valid = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_override", 32'(out_valid), 32'd0);
        end

        // Random traffic with random backpressure against the reference model.
        idle();
        n_acc = 0;
        n_out = 0;
        took  = 1'b0;
        for (int cyc = 0; cyc < 20000 && n_out < 1000; cyc++) begin
            @(negedge clk);
            if (!in_valid || took) begin
                if (n_acc < 1000 && $urandom_range(0, 4) != 0) begin
                    gen_random();
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("rand_unexpected_word", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rand_instr", out_instr, e.instr);
                    check("rand_err", 32'(out_err), 32'(e.err));
                    if (!e.err && e.fmt != 3'd0) begin
                        check("rand_roundtrip", imm_gen(e.fmt, out_instr), e.imm);
                    end
                end
            end
            took = in_valid && in_ready;
            if (took) begin
                exp_t e;
                model(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
                      in_imm, m_instr, m_err);
                e = '{instr: m_instr, err: m_err, fmt: in_fmt, imm: in_imm};
                sb.push_back(e);
                n_acc++;
            end
        end
        check("rand_accepted", 32'(n_acc), 32'd1000);
        check("rand_emitted", 32'(n_out), 32'd1000);
        check("rand_scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_instr_encoder
`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RV32I instruction encoder: the inverse of the immediate generator in fetch/decode. It packs format, opcode, register, funct and a full 32-bit signed immediate into a 32-bit instruction word, and flags immediates that the chosen format cannot represent. It sits in the self-test/stimulus path: the bench and the on-chip test sequencer use it to build instruction streams that feed fetch/decode and round-trip through ImmGen.

## Interface
Parameters:
- none; fixed RV32I encoding.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request this cycle.
- in_fmt  in  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J; 6 and 7 are illegal.
- in_opcode  in  7  instr[6:0].
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7 (R only).
- in_imm  in  32  signed immediate, byte offset for B/J, full value for U.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded instruction.
- out_err  out  1  immediate unrepresentable or illegal fmt.

## Operation
- Handshake on both sides: a transfer occurs when valid && ready on the same edge. out_valid and payload are held stable until accepted.
- Stage 1 (check): register request fields and compute fit:
  - I, S: -2048 ≤ imm ≤ 2047.
  - B: -4096 ≤ imm ≤ 4094, imm[0]=0.
  - J: -1048576 ≤ imm ≤ 1048574, imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm ignored, always fits.
  - fmt 6/7: err.
- Stage 2 (pack): standard RV32I field placement. Unused fields are zero, e.g. rd in S/B and rs2 in I.
  - I: imm[11:0] in [31:20].
  - S: imm[11:5]/imm[4:0].
  - B: imm[12|10:5] and imm[4:1|11].
  - U: imm[31:12].
  - J: imm[20|10:1|11|19:12].
- On err: out_instr = 32'h0000_0013 (NOP), out_err = 1. Never emit a truncated word.
- Invariant: when out_err = 0, ImmGen(out_instr) equals in_imm for I/S/B/U/J formats.

## Timing
- Reset values: out_valid 0, out_instr 0, out_err 0, both stage valids 0, in_ready 1 in the cycle after rst deasserts.
- Latency: 2 cycles from accepting edge to out_valid. Throughput 1 per cycle while out_ready = 1.
- Stage advances if next stage is empty or being drained this cycle. in_ready = !s1_valid || s1 advancing (combinational from out_ready).
- Full: both stages valid with out_ready = 0 drops in_ready to 0. Exactly 2 requests are buffered and none are lost.
- Simultaneous: drain and accept in the same cycle keeps occupancy constant. Order is always preserved.
- rst mid-operation clears all in-flight entries next edge, with no partial output. rst overrides in_valid on that edge.
- Unknown/illegal fmt does not stall; it flows through with err.

## Structure
- Shared header (alongside existing decode constants):
  - format codes FMT_R..FMT_J.
  - NOP constant 32'h0000_0013.
  - opcode constants reused from decode.
- One natural sub-module: imm_fit_check, combinational range/alignment check (fmt, imm → fits). It lives in stage 1 and is reusable by the sequencer.
- Stage registers and valid/ready logic stay in instr_encoder.

## Test plan
- I-type addi x1,x0,-1 (fmt 1, op 0010011, rd 1, imm 0xFFFFFFFF) → out_instr 0xFFF00093, err 0, out_valid 2 cycles after accept.
- S-type sw x2,-4(x3) (fmt 2, op 0100011, rs1 3, rs2 2, f3 010, imm -4) → 0xFE21AE23.
- J-type jal x1,2048 (fmt 5, op 1101111, rd 1, imm 0x800) → 0x001000EF.
- Error cases:
  - B-type imm 5 → out_instr 0x00000013, err 1.
  - I-type imm 2048 → err 1.
  - fmt 7 → err 1.
- Backpressure: out_ready = 0, drive 3 back-to-back requests → in_ready low after 2 accepted, third held. Release out_ready → three words emerge in order, none duplicated or lost.
- Reset and round-trip:
  - Assert rst with both stages full → next cycle out_valid 0, in_ready 1.
  - 1000 random legal requests: each out_instr fed to ImmGen returns in_imm.
